// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified instruction/data memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE_IF = 2'd1,
    ISSUE_D  = 2'd2,
    RESP     = 2'd3
  } state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_e;

  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  // Stores complete with a zero response; loads return the memory word.
  function automatic logic [63:0] data_resp(input logic we, input logic [63:0] rdata);
    return we ? 64'h0 : rdata;
  endfunction

endpackage

// File: rtl/unified_mem_arbiter.sv
// Arbitrates one single-ported 64-bit memory between instruction fetch and the
// MEM-stage data port; data has priority, bounded by a fetch starvation guard.
module unified_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int STREAK  = 4,
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [63:0] if_addr,
  input  logic        if_cancel,
  output logic        if_ready,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [63:0] d_addr,
  input  logic [63:0] d_wdata,
  output logic        d_ready,
  output logic [63:0] d_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [63:0] mem_rdata,
  output logic        err
);

  localparam int SW = $clog2(STREAK + 1);
  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  state_e          state_q, state_d;
  logic [SW-1:0]   streak_q, streak_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            drop_q, drop_d;
  logic            err_q, err_d;
  logic            mem_req_q, mem_req_d;
  logic            if_ready_q, if_ready_d;
  logic            d_ready_q, d_ready_d;
  owner_e          owner_q;
  logic            mem_we_q;
  logic [63:0]     mem_addr_q;
  logic [63:0]     mem_wdata_q;
  logic [31:0]     if_rdata_q;
  logic [63:0]     d_rdata_q;
  logic            fetch_ok_s;
  logic            grant_if_s;
  logic            grant_d_s;
  logic            acked_s;

  // A cancelled fetch in IDLE is treated as no fetch request at all.
  assign fetch_ok_s = if_req & ~if_cancel;

  // Control state, counters and pulse outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      streak_q   <= '0;
      tmo_q      <= '0;
      drop_q     <= 1'b0;
      err_q      <= 1'b0;
      mem_req_q  <= 1'b0;
      if_ready_q <= 1'b0;
      d_ready_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      streak_q   <= streak_d;
      tmo_q      <= tmo_d;
      drop_q     <= drop_d;
      err_q      <= err_d;
      mem_req_q  <= mem_req_d;
      if_ready_q <= if_ready_d;
      d_ready_q  <= d_ready_d;
    end
  end

  // Grant selection, issue/timeout handling and completion sequencing.
  always_comb begin
    state_d    = state_q;
    streak_d   = streak_q;
    tmo_d      = tmo_q;
    drop_d     = drop_q;
    err_d      = err_q;
    mem_req_d  = mem_req_q;
    if_ready_d = 1'b0;
    d_ready_d  = 1'b0;
    grant_if_s = 1'b0;
    grant_d_s  = 1'b0;
    acked_s    = 1'b0;

    case (state_q)
      IDLE: begin
        drop_d = 1'b0;
        if (d_req && !(fetch_ok_s && (streak_q == SW'(STREAK)))) begin
          grant_d_s = 1'b1;
          state_d   = ISSUE_D;
          mem_req_d = 1'b1;
          tmo_d     = '0;
          if (!if_req) begin
            streak_d = '0;
          end else if (streak_q != SW'(STREAK)) begin
            streak_d = streak_q + SW'(1);
          end else begin
            streak_d = streak_q;
          end
        end else if (fetch_ok_s) begin
          grant_if_s = 1'b1;
          state_d    = ISSUE_IF;
          mem_req_d  = 1'b1;
          tmo_d      = '0;
          streak_d   = '0;
        end else if (!if_req) begin
          streak_d = '0;
        end else begin
          streak_d = streak_q;
        end
      end

      ISSUE_IF, ISSUE_D: begin
        if ((state_q == ISSUE_IF) && if_cancel) begin
          drop_d = 1'b1;
        end else begin
          drop_d = drop_q;
        end
        // mem_ack takes precedence over an expiry in the same cycle.
        if (mem_ack || (tmo_q == TW'(TIMEOUT - 1))) begin
          acked_s   = mem_ack;
          err_d     = err_q | ~mem_ack;
          state_d   = RESP;
          mem_req_d = 1'b0;
          if (state_q == ISSUE_IF) begin
            if_ready_d = ~(drop_q | if_cancel);
          end else begin
            d_ready_d = 1'b1;
          end
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end

      RESP: begin
        if ((owner_q == OWN_IF) && if_cancel) begin
          drop_d = 1'b1;
        end else begin
          drop_d = drop_q;
        end
        state_d = IDLE;
      end

      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // Issue-field latch on grant and response latch on completion.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner_q     <= OWN_IF;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 64'h0;
      mem_wdata_q <= 64'h0;
      if_rdata_q  <= 32'h0;
      d_rdata_q   <= 64'h0;
    end else begin
      if (grant_d_s) begin
        owner_q     <= OWN_D;
        mem_we_q    <= d_we;
        mem_addr_q  <= d_addr;
        mem_wdata_q <= d_wdata;
      end else if (grant_if_s) begin
        owner_q     <= OWN_IF;
        mem_we_q    <= 1'b0;
        mem_addr_q  <= if_addr;
        mem_wdata_q <= 64'h0;
      end
      if (if_ready_d) begin
        if_rdata_q <= acked_s ? mem_rdata[31:0] : NOP_INSN;
      end
      if (d_ready_d) begin
        d_rdata_q <= acked_s ? data_resp(mem_we_q, mem_rdata) : 64'h0;
      end
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_ready  = if_ready_q;
  assign if_rdata  = if_rdata_q;
  assign d_ready   = d_ready_q;
  assign d_rdata   = d_rdata_q;
  assign err       = err_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed and randomized bench for unified_mem_arbiter against a
// transaction-level reference model.
module tb_unified_mem_arbiter;

  localparam int STREAK  = 4;
  localparam int TIMEOUT = 8;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, if_cancel, d_req, d_we, mem_ack;
  logic [63:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic        if_ready, d_ready, mem_req, mem_we, err;
  logic [31:0] if_rdata;
  logic [63:0] d_rdata, mem_addr, mem_wdata;

  int checks = 0;
  int failures = 0;

  // Reference model: what the outputs must show during the current cycle.
  int          m_phase;   // 0 idle, 1 memory transaction in flight, 2 completion
  bit          m_fetch;
  int          m_age;
  int          m_streak;
  bit          m_drop;
  bit          m_err;
  bit          m_req, m_we, m_if_rdy, m_d_rdy;
  logic [63:0] m_addr, m_wdata, m_d_data;
  logic [31:0] m_if_data;
  bit          hang;

  unified_mem_arbiter #(.STREAK(STREAK), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_cancel(if_cancel),
    .if_ready(if_ready), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_fetch = 1'b0; m_age = 0; m_streak = 0; m_drop = 1'b0;
    m_err = 1'b0; m_req = 1'b0; m_we = 1'b0; m_if_rdy = 1'b0; m_d_rdy = 1'b0;
    m_addr = 64'h0; m_wdata = 64'h0; m_d_data = 64'h0; m_if_data = 32'h0;
  endtask

  task automatic compare();
    chk("mem_req", 64'(mem_req), 64'(m_req));
    chk("mem_we", 64'(mem_we), 64'(m_we));
    chk("mem_addr", mem_addr, m_addr);
    chk("mem_wdata", mem_wdata, m_wdata);
    chk("if_ready", 64'(if_ready), 64'(m_if_rdy));
    chk("d_ready", 64'(d_ready), 64'(m_d_rdy));
    chk("err", 64'(err), 64'(m_err));
    if (m_if_rdy) chk("if_rdata", 64'(if_rdata), 64'(m_if_data));
    if (m_d_rdy) chk("d_rdata", d_rdata, m_d_data);
  endtask

  // Advance the model by one clock using the inputs presented this cycle.
  task automatic model_step();
    bit want_fetch;
    m_if_rdy = 1'b0;
    m_d_rdy  = 1'b0;
    if (m_phase == 0) begin
      m_drop = 1'b0;
      want_fetch = if_req && !if_cancel;
      if (d_req && !(want_fetch && m_streak >= STREAK)) begin
        m_phase = 1; m_fetch = 1'b0; m_age = 0; m_req = 1'b1;
        m_we = d_we; m_addr = d_addr; m_wdata = d_wdata;
        m_streak = if_req ? ((m_streak < STREAK) ? m_streak + 1 : STREAK) : 0;
      end else if (want_fetch) begin
        m_phase = 1; m_fetch = 1'b1; m_age = 0; m_req = 1'b1;
        m_we = 1'b0; m_addr = if_addr; m_wdata = 64'h0;
        m_streak = 0;
      end else if (!if_req) begin
        m_streak = 0;
      end
    end else if (m_phase == 1) begin
      if (m_fetch && if_cancel) m_drop = 1'b1;
      m_age++;
      if (mem_ack || m_age == TIMEOUT) begin
        if (!mem_ack) m_err = 1'b1;
        m_req = 1'b0;
        m_phase = 2;
        if (m_fetch) begin
          if (!m_drop) begin
            m_if_rdy = 1'b1;
            m_if_data = mem_ack ? mem_rdata[31:0] : NOP;
          end
        end else begin
          m_d_rdy = 1'b1;
          m_d_data = (mem_ack && !m_we) ? mem_rdata : 64'h0;
        end
      end
    end else begin
      m_phase = 0;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    compare();
  endtask

  task automatic idle_inputs();
    if_req = 1'b0; if_cancel = 1'b0; d_req = 1'b0; d_we = 1'b0; mem_ack = 1'b0;
    if_addr = 64'h0; d_addr = 64'h0; d_wdata = 64'h0; mem_rdata = 64'h0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b0;
    #1;
    model_reset();
    compare();
    repeat (2) @(negedge clk);
    compare();
    reset = 1'b1;
  endtask

  initial begin
    int hi;
    bit seen;
    int n;
    logic [63:0] grants [10];

    reset = 1'b1;
    idle_inputs();
    @(negedge clk);
    do_reset();
    chk("rst_mem_req", 64'(mem_req), 64'h0);
    chk("rst_err", 64'(err), 64'h0);

    // Lone load: ack on the second issue cycle.
    d_req = 1'b1; d_we = 1'b0; d_addr = 64'h40;
    tick();
    chk("load_c1_req", 64'(mem_req), 64'h1);
    chk("load_c1_addr", mem_addr, 64'h40);
    tick();
    chk("load_c2_req", 64'(mem_req), 64'h1);
    mem_ack = 1'b1; mem_rdata = 64'hDEAD;
    tick();
    chk("load_c3_ready", 64'(d_ready), 64'h1);
    chk("load_c3_rdata", d_rdata, 64'hDEAD);
    chk("load_c3_req", 64'(mem_req), 64'h0);
    d_req = 1'b0; mem_ack = 1'b0;
    tick();
    chk("load_c4_ready", 64'(d_ready), 64'h0);
    chk("load_err", 64'(err), 64'h0);

    // Store held until ack; response data is zero.
    d_req = 1'b1; d_we = 1'b1; d_wdata = 64'h1234; d_addr = 64'h80;
    tick();
    chk("store_we", 64'(mem_we), 64'h1);
    chk("store_wdata", mem_wdata, 64'h1234);
    tick();
    chk("store_hold_wdata", mem_wdata, 64'h1234);
    chk("store_hold_addr", mem_addr, 64'h80);
    mem_ack = 1'b1; mem_rdata = 64'hFFFF_0000_5555_AAAA;
    tick();
    chk("store_ready", 64'(d_ready), 64'h1);
    chk("store_rdata", d_rdata, 64'h0);
    d_req = 1'b0; d_we = 1'b0; mem_ack = 1'b0;
    tick();

    // Data timeout.
    d_req = 1'b1; d_addr = 64'h100;
    hi = 0; seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      tick();
      if (mem_req) hi++;
      if (d_ready) begin
        seen = 1'b1;
        chk("tmo_d_rdata", d_rdata, 64'h0);
        d_req = 1'b0;
      end
    end
    chk("tmo_d_seen", 64'(seen), 64'h1);
    chk("tmo_d_len", 64'(hi), 64'd8);
    chk("tmo_d_err", 64'(err), 64'h1);
    tick();

    // Fetch timeout returns a NOP; err stays set.
    if_req = 1'b1; if_addr = 64'h200;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      tick();
      if (if_ready) begin
        seen = 1'b1;
        chk("tmo_if_rdata", 64'(if_rdata), 64'h13);
        if_req = 1'b0;
      end
    end
    chk("tmo_if_seen", 64'(seen), 64'h1);
    tick();
    chk("tmo_err_sticky", 64'(err), 64'h1);
    do_reset();
    chk("err_cleared", 64'(err), 64'h0);

    // Cancelled fetch completes at memory but never reports ready.
    if_req = 1'b1; if_addr = 64'h300;
    tick();
    chk("cancel_issue", 64'(mem_req), 64'h1);
    if_cancel = 1'b1; if_req = 1'b0;
    tick();
    if_cancel = 1'b0; mem_ack = 1'b1; mem_rdata = 64'h1111;
    tick();
    chk("cancel_no_ready", 64'(if_ready), 64'h0);
    mem_ack = 1'b0;
    tick();
    if_req = 1'b1; if_addr = 64'h340;
    tick();
    chk("after_cancel_addr", mem_addr, 64'h340);
    mem_ack = 1'b1; mem_rdata = 64'h0000_0000_CAFE_F00D;
    tick();
    chk("after_cancel_ready", 64'(if_ready), 64'h1);
    chk("after_cancel_rdata", 64'(if_rdata), 64'hCAFE_F00D);
    if_req = 1'b0; mem_ack = 1'b0;
    tick();

    // Asynchronous reset during a data issue, then a stale ack.
    d_req = 1'b1; d_addr = 64'h500;
    tick();
    chk("mid_issue_req", 64'(mem_req), 64'h1);
    #2 reset = 1'b0;
    #1 chk("async_drop_req", 64'(mem_req), 64'h0);
    model_reset();
    @(negedge clk);
    idle_inputs();
    reset = 1'b1;
    mem_ack = 1'b1; mem_rdata = 64'h77;
    tick();
    chk("stale_ack_d", 64'(d_ready), 64'h0);
    mem_ack = 1'b0;
    tick();
    chk("stale_ack_d2", 64'(d_ready), 64'h0);
    chk("stale_ack_if", 64'(if_ready), 64'h0);

    // Contention: both ports always requesting, immediate acks.
    do_reset();
    if_req = 1'b1; if_addr = 64'h1000;
    d_req = 1'b1; d_we = 1'b0; d_addr = 64'h2000;
    n = 0;
    for (int k = 0; k < 80 && n < 10; k++) begin
      if (mem_req) begin
        grants[n] = mem_addr;
        n++;
        mem_ack = 1'b1;
      end else begin
        mem_ack = 1'b0;
      end
      tick();
    end
    chk("contention_count", 64'(n), 64'd10);
    for (int i = 0; i < n; i++)
      chk($sformatf("grant_order_%0d", i), grants[i], (i % 5 == 4) ? 64'h1000 : 64'h2000);
    idle_inputs();
    repeat (3) tick();

    // Randomized traffic checked every cycle against the model.
    do_reset();
    hang = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      if_cancel = 1'b0;
      if (if_req && m_if_rdy) if_req = 1'b0;
      if (d_req && m_d_rdy) d_req = 1'b0;
      if (if_req && m_phase == 1 && m_fetch && ($urandom % 8) == 0) begin
        if_cancel = 1'b1;
        if_req = 1'b0;
      end else if (!if_req && ($urandom % 3) == 0) begin
        if_req = 1'b1;
        if_addr = {$urandom(), $urandom()};
      end
      if (!d_req && ($urandom % 2) == 0) begin
        d_req = 1'b1;
        d_we = 1'(($urandom % 3) == 0);
        d_addr = {$urandom(), $urandom()};
        d_wdata = {$urandom(), $urandom()};
      end
      if (m_phase != 1) hang = (($urandom % 12) == 0);
      mem_ack = hang ? 1'b0 : 1'(($urandom % 3) == 0);
      mem_rdata = {$urandom(), $urandom()};
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/unified_mem_arbiter.md
# unified_mem_arbiter

Shares one single-ported 64-bit memory between the pipeline's instruction-fetch port and its MEM-stage data port. It sits between the pipelined core and the unified memory. It serialises requests with data-port priority plus a fetch starvation guard, and returns completions with a one-cycle ready pulse. A hung transaction is bounded by a timeout that returns a safe value and raises a sticky error.

## Interface
- STREAK, 4: consecutive data grants allowed while a fetch waits before fetch is forced.
- TIMEOUT, 64: cycles a transaction may stay outstanding before abort.
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low (0 = reset).
- if_req  in  1  fetch request; held until if_ready or if_cancel.
- if_addr  in  64  fetch byte address.
- if_cancel  in  1  branch flush; drops the pending/outstanding fetch response.
- if_ready  out  1  one-cycle pulse: if_rdata valid.
- if_rdata  out  32  fetched instruction.
- d_req  in  1  data request; held until d_ready.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  64  data byte address.
- d_wdata  in  64  store data.
- d_ready  out  1  one-cycle pulse: load data valid / store done.
- d_rdata  out  64  load data.
- mem_req  out  1  held high until mem_ack or timeout.
- mem_we  out  1  write enable to memory.
- mem_addr  out  64  latched address.
- mem_wdata  out  64  latched store data.
- mem_ack  in  1  one-cycle completion from memory.
- mem_rdata  in  64  read data, valid with mem_ack.
- err  out  1  sticky timeout flag.

## Operation
- States: IDLE, ISSUE_IF, ISSUE_D, RESP.
- IDLE: grant selection.
  - d_req only: ISSUE_D.
  - if_req only (and not if_cancel): ISSUE_IF.
  - Both: ISSUE_D, unless the streak counter equals STREAK, in which case ISSUE_IF.
  - On grant, latch addr, wdata, we, and owner into the issue registers. A fetch grant forces mem_we=0.
- Streak counter, 0..STREAK:
  - Increments on each data grant made while if_req is high.
  - Clears on a fetch grant or when if_req is low in IDLE.
  - Saturates at STREAK.
- ISSUE_x: mem_req=1 with the latched fields.
  - On mem_ack, latch the response and go to RESP.
  - A fetch response is mem_rdata[31:0].
  - A data response is mem_rdata for loads and 0 for stores.
- Timeout counter: clears on grant and increments each ISSUE cycle without mem_ack.
  - Reaching TIMEOUT-1 without mem_ack: drop mem_req and set err.
  - The response is 32'h00000013 (NOP) for fetch and 64'h0 for data; go to RESP.
- RESP: pulse the owner's ready for one cycle, then return to IDLE.
- Fetch cancel: if_cancel seen in ISSUE_IF or RESP (fetch owner) sets a drop flag.
  - The memory transaction still completes.
  - if_ready is suppressed in RESP.
  - The drop flag clears on return to IDLE.
- mem_ack in IDLE or RESP is ignored, including a stale ack after reset.
- Address alignment is passed through unchanged; the memory owns alignment.

## Timing
- Reset values: all outputs 0, state IDLE, counters 0, drop flag 0, err 0.
- Reset mid-transaction drops mem_req immediately (asynchronous).
- Minimum latency: request high at cycle 0 (IDLE).
  - Cycle 1: mem_req=1.
  - mem_ack at cycle 1 gives ready at cycle 2.
  - IDLE again at cycle 3.
  - Every further ack cycle adds one.
- Requesters drop req no later than the cycle after ready. Because ready is registered, IDLE at cycle 3 samples only new requests.
- mem_addr, mem_we and mem_wdata are stable for the whole mem_req assertion.
- if_rdata and d_rdata are valid only while the respective ready is high; otherwise they hold their last value.
- One transaction is outstanding at a time, so throughput is at most one per 3 cycles.
- Simultaneous events in the same cycle:
  - mem_ack and the timeout expiry: mem_ack wins and err stays unchanged.
  - if_cancel and the fetch grant in IDLE: no grant is made.

## Structure
- The shared package `mem_arb_pkg` holds:
  - The state enum: IDLE=2'd0, ISSUE_IF=2'd1, ISSUE_D=2'd2, RESP=2'd3.
  - The owner encoding.
  - The NOP constant 32'h00000013.
- No sub-module; a single module with one state register block and one datapath latch block.

## Test plan
- Lone load: d_req, d_addr=0x40, ack after 2 cycles with rdata=0xDEAD → mem_req cycles 1–2, d_ready at cycle 3, d_rdata=0xDEAD, err=0.
- Contention: if_req and d_req both high every cycle, STREAK=4 → grant order D,D,D,D,IF,D…; the fetch wait never exceeds 4 data transactions.
- Cancel: fetch granted, if_cancel pulsed while ISSUE_IF, ack arrives → no if_ready; the next request is granted normally.
- Timeout: d_req with no mem_ack, TIMEOUT=8 → mem_req drops after 8 cycles, d_ready with d_rdata=0, err=1 until reset; a repeated fetch timeout returns if_rdata=32'h00000013.
- Reset mid-issue: reset=0 during ISSUE_D → mem_req=0 the same cycle. After release, a stale mem_ack in IDLE produces no ready.
- Store: d_we=1, d_wdata=0x1234, addr=0x80 → mem_we=1 with mem_wdata=0x1234 held until ack; d_ready pulses with d_rdata=0.
